exp_test_unit_checker: RTL and testbench
========================================

# exp_test_unit_checker

Receive-side checker for test-unit traffic. It accepts a valid/ready/last byte stream, such as the output of `exp_test_unit` or of a DUT driven by it, and compares every beat against an internally generated incrementing reference sequence. It counts data and framing errors, counts packets, detects a stalled stream by timeout, and reports a sticky pass/fail at the end of a run. It sits at the sink end of a test bench or on-chip self-test path. It is the consuming end of the stimulus that the test unit produces.

## Interface
Parameters:
- `DSIZE`, 8: data width in bits.
- `SEED`, 8'h5A: first expected data value of a run (DSIZE bits).
- `PKT_LEN`, 16: beats per packet, ≥ 1.
- `NUM_PKTS`, 4: packets per run, ≥ 1.
- `TIMEOUT`, 1024: maximum RUN cycles allowed without an accepted beat, ≥ 2.

Ports:
- `clock` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle start pulse.
- `s_tdata` in DSIZE: stream data.
- `s_tvalid` in 1: stream valid.
- `s_tlast` in 1: end-of-packet marker.
- `s_tready` out 1: stream ready, registered.
- `busy` out 1: high while in RUN.
- `done` out 1: run finished, level.
- `pass` out 1: done with zero errors, level.
- `timeout` out 1: run ended by timeout, level.
- `err_cnt` out 16: error count, saturates at 16'hFFFF.
- `pkt_cnt` out 16: packets closed in this run.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **Reset** (`rst_n`=0 on a rising edge), which applies in any state and also mid-run:
  - State goes to IDLE.
  - `s_tready`, `busy`, `done`, `pass`, `timeout` go to 0.
  - `err_cnt`, `pkt_cnt`, the beat index and the idle counter go to 0.
  - The expected value goes to `SEED`.
- **IDLE**:
  - `s_tready`=0.
  - `start`=1 moves the FSM to RUN and clears `err_cnt`, `pkt_cnt`, the beat index and the idle counter.
  - The same `start` loads the expected value with `SEED`.
- **RUN**:
  - `s_tready`=1 and `busy`=1.
  - A beat is accepted on `s_tvalid & s_tready`.
  - For each accepted beat, `last_exp = (beat_idx == PKT_LEN-1)`.
  - The beat is an error if `s_tdata != expected` or `s_tlast != last_exp`. Each beat adds at most 1 to `err_cnt`, even when both conditions fail.
  - The expected value increments modulo 2^DSIZE on every accepted beat, whether or not the beat matched. It runs continuously across packets (0xFF→0x00).
  - A beat with `s_tlast`=1 increments `pkt_cnt` and resets `beat_idx` to 0. This holds for early tlast too.
  - A beat with `s_tlast`=0 increments `beat_idx`, saturating at PKT_LEN-1. Once saturated, every further non-last beat is counted as an error.
  - The idle counter clears on each accepted beat and increments on every other RUN cycle.
- **RUN exits**:
  - The FSM goes to DONE when the accepted tlast brings `pkt_cnt` to `NUM_PKTS`.
  - It also goes to DONE when the idle counter reaches `TIMEOUT`. In that case `timeout`=1 and `err_cnt` is incremented by 1.
- **DONE**:
  - `s_tready`=0, `done`=1, and `pass = (err_cnt == 0)`.
  - All outputs hold.
  - `start` re-enters RUN with the same clearing as from IDLE, and `done`, `pass` and `timeout` drop.
- `start` while in RUN is ignored.
- Beats presented while `s_tready`=0 are not accepted and are not checked.

## Timing
- `start` is sampled at cycle N. `busy` and `s_tready` are high from cycle N+1.
- Per-beat check latency is 1 cycle: `err_cnt` and `pkt_cnt` reflect a beat accepted at cycle N from cycle N+1.
- The final tlast accepted at cycle N gives `done`/`pass` high and `s_tready` low at cycle N+1. No beat is accepted at N+1.
- Timeout: when `TIMEOUT` consecutive RUN cycles pass without an accepted beat, `done` and `timeout` are high on the following cycle.
- `s_tvalid` may toggle freely, so bubbles are legal. Throughput is 1 beat per cycle while valid is held.
- Saturation: `err_cnt` stays at 16'hFFFF once reached, with no wrap.

## Test plan
All scenarios use DSIZE=8, SEED=0x5A, PKT_LEN=4, NUM_PKTS=2, TIMEOUT=8 unless stated.
- **Clean run**: after `start`, send 0x5A..0x61 with tlast on beats 4 and 8, valid held high. Required: `done`=1 and `pass`=1 one cycle after the last beat, `err_cnt`=0, `pkt_cnt`=2, `timeout`=0.
- **Corrupt data plus bubbles**: same stream, with beat 3 sent as 0x00 and valid low on every other cycle. Required: `err_cnt`=1, `pass`=0, `pkt_cnt`=2. Later beats still match because the expected value keeps incrementing.
- **Framing errors**: tlast on beat 2, then 6 beats with tlast on the last of them; data correct. Required:
  - The early tlast counts as 1 error.
  - The second packet's 4th beat without tlast counts as 1 error.
  - The overrun beats count as 1 error each.
  - `pkt_cnt`=2, `done`=1.
- **Wrap**: SEED=0xFE with 0xFE, 0xFF, 0x00, 0x01 in each packet sequence continuing. Required: `err_cnt`=0.
- **Timeout**: `start`, 2 correct beats, then valid held low. Required: `done`=1 and `timeout`=1 after 8 idle cycles plus 1, `err_cnt`=1, `pass`=0.
- **Reset and restart**: drop `rst_n` mid-packet. Required: all outputs 0 on the next cycle. A new `start` followed by a clean run gives `pass`=1. A `start` issued in DONE also reruns cleanly.

Source files
------------

// File: rtl/exp_test_unit_checker.sv
// Sink-side checker for test-unit byte streams: compares beats to an
// incrementing reference and reports error/packet counts and pass/fail.
module exp_test_unit_checker #(
   parameter int               DSIZE    = 8,
   parameter logic [DSIZE-1:0] SEED     = DSIZE'(8'h5A),
   parameter int               PKT_LEN  = 16,
   parameter int               NUM_PKTS = 4,
   parameter int               TIMEOUT  = 1024
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DSIZE-1:0] s_tdata,
   input  logic             s_tvalid,
   input  logic             s_tlast,
   output logic             s_tready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [15:0]      err_cnt,
   output logic [15:0]      pkt_cnt
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
   localparam logic [15:0]   PKT_TGT  = 16'(NUM_PKTS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic             tready_q, tready_d;
   logic             tmo_q, tmo_d;
   logic [15:0]      err_q, err_d;
   logic [15:0]      pkt_q, pkt_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [DSIZE-1:0] exp_q, exp_d;

   logic        accept;
   logic        last_exp;
   logic        bad;
   logic [15:0] err_inc;
   logic [15:0] pkt_inc;

   assign accept   = s_tvalid & tready_q & (state_q == S_RUN);
   assign last_exp = (beat_q == LAST_IDX);
   assign bad      = (s_tdata != exp_q) | (s_tlast != last_exp);
   assign err_inc  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
   assign pkt_inc  = pkt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      pkt_d   = pkt_q;
      beat_d  = beat_q;
      idle_d  = idle_q;
      exp_d   = exp_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               tmo_d   = 1'b0;
               err_d   = '0;
               pkt_d   = '0;
               beat_d  = '0;
               idle_d  = '0;
               exp_d   = SEED;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (bad) err_d = err_inc;
               exp_d  = exp_q + DSIZE'(1);
               idle_d = '0;
               if (s_tlast) begin
                  pkt_d  = pkt_inc;
                  beat_d = '0;
                  if (pkt_inc == PKT_TGT) state_d = S_DONE;
               end else if (beat_q != LAST_IDX) begin
                  beat_d = beat_q + BW'(1);
               end
            end else begin
               idle_d = idle_q + IW'(1);
               // Stall limit reached: close the run and charge one error.
               if (idle_q == IDLE_MAX) begin
                  state_d = S_DONE;
                  tmo_d   = 1'b1;
                  err_d   = err_inc;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      tready_d = (state_d == S_RUN);
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         tready_q <= 1'b0;
         tmo_q    <= 1'b0;
         err_q    <= '0;
         pkt_q    <= '0;
         beat_q   <= '0;
         idle_q   <= '0;
         exp_q    <= SEED;
      end else begin
         state_q  <= state_d;
         tready_q <= tready_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         pkt_q    <= pkt_d;
         beat_q   <= beat_d;
         idle_q   <= idle_d;
         exp_q    <= exp_d;
      end
   end

   assign s_tready = tready_q;
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign pass     = (state_q == S_DONE) && (err_q == 16'd0);
   assign timeout  = tmo_q;
   assign err_cnt  = err_q;
   assign pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_exp_test_unit_checker.sv
// Bench for exp_test_unit_checker: scoreboard of expected counts per beat
// plus end-of-run status checks, on a SEED=0x5A and a SEED=0xFE instance.
module tb_exp_test_unit_checker;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_w = 1'b0;
   logic [7:0] s_tdata = '0;
   logic       s_tvalid = 1'b0;
   logic       s_tlast = 1'b0;

   logic        rdy_a, busy_a, done_a, pass_a, tmo_a;
   logic [15:0] err_a, pkt_a;
   logic        rdy_w, busy_w, done_w, pass_w, tmo_w;
   logic [15:0] err_w, pkt_w;

   logic        use_w = 1'b0;
   logic        o_rdy, o_busy, o_done, o_pass, o_tmo;
   logic [15:0] o_err, o_pkt;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [15:0] err;
      logic [15:0] pkt;
      logic        done;
   } exp_t;
   exp_t sb[$];

   logic [7:0]  m_exp;
   int          m_idx;
   logic [15:0] m_err;
   logic [15:0] m_pkt;

   always #5 clock = ~clock;

   exp_test_unit_checker #(
      .DSIZE(8), .SEED(8'h5A), .PKT_LEN(4), .NUM_PKTS(2), .TIMEOUT(8)
   ) dut (
      .clock(clock), .rst_n(rst_n), .start(start_a),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(rdy_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .timeout(tmo_a), .err_cnt(err_a), .pkt_cnt(pkt_a)
   );

   exp_test_unit_checker #(
      .DSIZE(8), .SEED(8'hFE), .PKT_LEN(4), .NUM_PKTS(2), .TIMEOUT(8)
   ) dut_w (
      .clock(clock), .rst_n(rst_n), .start(start_w),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(rdy_w), .busy(busy_w), .done(done_w), .pass(pass_w),
      .timeout(tmo_w), .err_cnt(err_w), .pkt_cnt(pkt_w)
   );

   assign o_rdy  = use_w ? rdy_w  : rdy_a;
   assign o_busy = use_w ? busy_w : busy_a;
   assign o_done = use_w ? done_w : done_a;
   assign o_pass = use_w ? pass_w : pass_a;
   assign o_tmo  = use_w ? tmo_w  : tmo_a;
   assign o_err  = use_w ? err_w  : err_a;
   assign o_pkt  = use_w ? pkt_w  : pkt_a;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [7:0] seed);
      if (use_w) start_w = 1'b1;
      else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_w = 1'b0;
      m_exp = seed;
      m_idx = 0;
      m_err = '0;
      m_pkt = '0;
      n_chk++;
      if (o_busy !== 1'b1 || o_rdy !== 1'b1 || o_done !== 1'b0) begin
         $display("FAIL start: busy=%b rdy=%b done=%b want 1 1 0",
                  o_busy, o_rdy, o_done);
      end else n_pass++;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      exp_t e;
      logic last_exp;
      last_exp = (m_idx == 3);
      if ((d != m_exp || l != last_exp) && m_err != 16'hFFFF) m_err++;
      m_exp = m_exp + 8'd1;
      if (l) begin
         m_pkt++;
         m_idx = 0;
      end else if (m_idx < 3) m_idx++;
      e.err  = m_err;
      e.pkt  = m_pkt;
      e.done = l && (m_pkt == 16'd2);
      sb.push_back(e);
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      e = sb.pop_front();
      n_chk++;
      if (o_err !== e.err || o_pkt !== e.pkt || o_done !== e.done) begin
         $display("FAIL beat %h: err=%0d pkt=%0d done=%b want %0d %0d %b",
                  d, o_err, o_pkt, o_done, e.err, e.pkt, e.done);
      end else n_pass++;
   endtask

   task automatic clean_run(input logic [7:0] seed, input string nm);
      logic [7:0] d;
      do_start(seed);
      for (int i = 0; i < 8; i++) begin
         d = seed + 8'(i);
         send(d, (i == 3) || (i == 7));
      end
      n_chk++;
      if (o_done !== 1'b1 || o_pass !== 1'b1 || o_tmo !== 1'b0 ||
          o_err !== 16'd0 || o_pkt !== 16'd2 || o_rdy !== 1'b0) begin
         $display("FAIL %s: done=%b pass=%b tmo=%b err=%0d pkt=%0d rdy=%b want 1 1 0 0 2 0",
                  nm, o_done, o_pass, o_tmo, o_err, o_pkt, o_rdy);
      end else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({o_rdy, o_busy, o_done, o_pass, o_tmo} !== 5'b0 ||
          o_err !== 16'd0 || o_pkt !== 16'd0) begin
         $display("FAIL reset: rdy=%b busy=%b done=%b pass=%b tmo=%b err=%0d pkt=%0d want all 0",
                  o_rdy, o_busy, o_done, o_pass, o_tmo, o_err, o_pkt);
      end else n_pass++;
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (o_rdy !== 1'b0 || o_busy !== 1'b0) begin
         $display("FAIL idle: rdy=%b busy=%b want 0 0", o_rdy, o_busy);
      end else n_pass++;
   endtask

   task automatic test_clean();
      clean_run(8'h5A, "clean");
   endtask

   task automatic test_corrupt_bubbles();
      logic [7:0] d;
      do_start(8'h5A);
      for (int i = 0; i < 8; i++) begin
         d = (i == 2) ? 8'h00 : 8'h5A + 8'(i);
         send(d, (i == 3) || (i == 7));
         if (i != 7) tick();
      end
      n_chk++;
      if (o_done !== 1'b1 || o_pass !== 1'b0 || o_err !== 16'd1 ||
          o_pkt !== 16'd2) begin
         $display("FAIL corrupt: done=%b pass=%b err=%0d pkt=%0d want 1 0 1 2",
                  o_done, o_pass, o_err, o_pkt);
      end else n_pass++;
   endtask

   task automatic test_framing();
      logic [7:0] d;
      do_start(8'h5A);
      for (int i = 0; i < 8; i++) begin
         d = 8'h5A + 8'(i);
         send(d, (i == 1) || (i == 7));
      end
      n_chk++;
      if (o_done !== 1'b1 || o_pass !== 1'b0 || o_err !== 16'd3 ||
          o_pkt !== 16'd2) begin
         $display("FAIL framing: done=%b pass=%b err=%0d pkt=%0d want 1 0 3 2",
                  o_done, o_pass, o_err, o_pkt);
      end else n_pass++;
   endtask

   task automatic test_wrap();
      use_w = 1'b1;
      #1;
      clean_run(8'hFE, "wrap");
      use_w = 1'b0;
      #1;
   endtask

   task automatic test_timeout();
      do_start(8'h5A);
      send(8'h5A, 1'b0);
      send(8'h5B, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      n_chk++;
      if (o_done !== 1'b0 || o_busy !== 1'b1) begin
         $display("FAIL tmo_early: done=%b busy=%b want 0 1", o_done, o_busy);
      end else n_pass++;
      tick();
      n_chk++;
      if (o_done !== 1'b1 || o_tmo !== 1'b1 || o_err !== 16'd1 ||
          o_pass !== 1'b0 || o_pkt !== 16'd0) begin
         $display("FAIL timeout: done=%b tmo=%b err=%0d pass=%b pkt=%0d want 1 1 1 0 0",
                  o_done, o_tmo, o_err, o_pass, o_pkt);
      end else n_pass++;
   endtask

   task automatic test_reset_restart();
      do_start(8'h5A);
      send(8'h11, 1'b0);
      send(8'h5B, 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = 8'h5C;
      rst_n    = 1'b0;
      tick();
      s_tvalid = 1'b0;
      n_chk++;
      if ({o_rdy, o_busy, o_done, o_pass, o_tmo} !== 5'b0 ||
          o_err !== 16'd0 || o_pkt !== 16'd0) begin
         $display("FAIL midreset: rdy=%b busy=%b done=%b pass=%b tmo=%b err=%0d pkt=%0d want all 0",
                  o_rdy, o_busy, o_done, o_pass, o_tmo, o_err, o_pkt);
      end else n_pass++;
      rst_n = 1'b1;
      tick();
      clean_run(8'h5A, "restart");
      clean_run(8'h5A, "rerun_done");
   endtask

   task automatic test_start_in_run();
      do_start(8'h5A);
      send(8'h5A, 1'b0);
      start_a = 1'b1;
      send(8'h5B, 1'b0);
      start_a = 1'b0;
      send(8'h5C, 1'b0);
      send(8'h5D, 1'b1);
      n_chk++;
      if (o_pkt !== 16'd1 || o_err !== 16'd0 || o_busy !== 1'b1) begin
         $display("FAIL start_in_run: pkt=%0d err=%0d busy=%b want 1 0 1",
                  o_pkt, o_err, o_busy);
      end else n_pass++;
      for (int i = 0; i < 4; i++) send(8'h5E + 8'(i), i == 3);
   endtask

   initial begin
      test_reset();
      test_clean();
      test_corrupt_bubbles();
      test_framing();
      test_wrap();
      test_timeout();
      test_reset_restart();
      test_start_in_run();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
